mem_initiator: RTL and testbench

Bus-master side of the LC-3 memory handshake. Takes single read/write requests from the control/datapath (fetch, LD/ST family), sequences MAR load, MDR load, and memory enable over the shared 16-bit bus, and waits for the memory ready flag `r`. It returns read data or write completion to the client, and raises an error if `r` never arrives. It sits between the control FSM and the memory block and owns every memory-side strobe.

---
 rtl/mem_initiator.sv | 164 ++++++++++++++++
 tb/tb_mem_initiator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_initiator
// Purpose  : LC-3 bus master: sequences MAR/MDR loads and memory enable over
//            the shared bus, waits for ready, returns read data or timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_initiator #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic        byte_mode,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] bus_out,
    output logic        bus_oe,
    output logic        load_mar,
    output logic        load_mdr,
    output logic        mio_en,
    output logic        r_w,
    output logic        data_size,
    output logic        mdr_en,
    input  logic [15:0] mdr_in,
    input  logic        r
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_MAR    = 3'd1;
    localparam logic [2:0] c_ST_MDRW   = 3'd2;
    localparam logic [2:0] c_ST_ACCESS = 3'd3;
    localparam logic [2:0] c_ST_LOAD   = 3'd4;
    localparam logic [2:0] c_ST_OUT    = 3'd5;
    localparam logic [2:0] c_ST_DONE   = 3'd6;

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic        r_we;
    logic        r_byte;
    logic [15:0] r_wdata;
    logic [7:0]  r_count;

    // Outputs are registered for the state being entered, so every strobe
    // defaults low each cycle and only the target state's group is raised.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_we      <= 1'b0;
            r_byte    <= 1'b0;
            r_wdata   <= 16'h0000;
            r_count   <= 8'h00;
            busy      <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= 16'h0000;
            bus_out   <= 16'h0000;
            bus_oe    <= 1'b0;
            load_mar  <= 1'b0;
            load_mdr  <= 1'b0;
            mio_en    <= 1'b0;
            r_w       <= 1'b0;
            data_size <= 1'b0;
            mdr_en    <= 1'b0;
        end else begin
            busy      <= 1'b1;
            ack       <= 1'b0;
            err       <= 1'b0;
            bus_out   <= 16'h0000;
            bus_oe    <= 1'b0;
            load_mar  <= 1'b0;
            load_mdr  <= 1'b0;
            mio_en    <= 1'b0;
            r_w       <= 1'b0;
            data_size <= 1'b0;
            mdr_en    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    busy <= 1'b0;
                    if (req) begin
                        r_we     <= we;
                        r_byte   <= byte_mode;
                        r_wdata  <= wdata;
                        busy     <= 1'b1;
                        bus_out  <= addr;
                        bus_oe   <= 1'b1;
                        load_mar <= 1'b1;
                        r_state  <= c_ST_MAR;
                    end
                end
                c_ST_MAR: begin
                    if (r_we) begin
                        bus_out  <= r_byte ? {8'h00, r_wdata[7:0]} : r_wdata;
                        bus_oe   <= 1'b1;
                        load_mdr <= 1'b1;
                        r_state  <= c_ST_MDRW;
                    end else begin
                        mio_en    <= 1'b1;
                        r_w       <= 1'b0;
                        data_size <= r_byte;
                        r_count   <= 8'h00;
                        r_state   <= c_ST_ACCESS;
                    end
                end
                c_ST_MDRW: begin
                    mio_en    <= 1'b1;
                    r_w       <= 1'b1;
                    data_size <= r_byte;
                    r_count   <= 8'h00;
                    r_state   <= c_ST_ACCESS;
                end
                c_ST_ACCESS: begin
                    if (r) begin
                        if (r_we) begin
                            ack     <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else begin
                            load_mdr <= 1'b1;
                            mio_en   <= 1'b1;
                            r_state  <= c_ST_LOAD;
                        end
                    end else if (r_count == c_TO_LAST) begin
                        ack     <= 1'b1;
                        err     <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        mio_en    <= 1'b1;
                        r_w       <= r_we;
                        data_size <= r_byte;
                        if (r_count != 8'hFF) begin
                            r_count <= r_count + 8'h01;
                        end
                    end
                end
                c_ST_LOAD: begin
                    mdr_en  <= 1'b1;
                    r_state <= c_ST_OUT;
                end
                c_ST_OUT: begin
                    // Byte reads return the high byte of the MDR, zero-extended.
                    rdata   <= r_byte ? {8'h00, mdr_in[15:8]} : mdr_in;
                    ack     <= 1'b1;
                    r_state <= c_ST_DONE;
                end
                c_ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_initiator
// Purpose  : Self-checking bench for mem_initiator against a transaction-level
//            model of the memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_initiator;

    localparam int C_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic        byte_mode;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] bus_out;
    logic        bus_oe;
    logic        load_mar;
    logic        load_mdr;
    logic        mio_en;
    logic        r_w;
    logic        data_size;
    logic        mdr_en;
    logic [15:0] mdr_in;
    logic        r;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_rdata;

    always #5 clk = ~clk;

    mem_initiator #(.TIMEOUT(C_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .byte_mode (byte_mode),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .load_mar  (load_mar),
        .load_mdr  (load_mdr),
        .mio_en    (mio_en),
        .r_w       (r_w),
        .data_size (data_size),
        .mdr_en    (mdr_en),
        .mdr_in    (mdr_in),
        .r         (r)
    );

    wire [25:0] w_act = {busy, ack, err, bus_oe, bus_out, load_mar, load_mdr,
                         mio_en, r_w, data_size, mdr_en};

    function automatic logic [25:0] f_vec(input logic b, input logic a,
                                          input logic e, input logic oe,
                                          input logic [15:0] bus,
                                          input logic lmar, input logic lmdr,
                                          input logic mio, input logic rw,
                                          input logic ds, input logic men);
        return {b, a, e, oe, bus, lmar, lmdr, mio, rw, ds, men};
    endfunction

    // One request issued while the DUT idles; r stays low for trdel cycles of
    // the access phase. Ends at the idle cycle following the ack.
    task automatic run_txn(input logic twe, input logic tbm,
                           input logic [15:0] taddr, input logic [15:0] twd,
                           input int trdel, input logic [15:0] tmdr,
                           input string name);
        logic [25:0] exp_q[$];
        logic        to;
        int          n_acc;
        int          a_start;
        int          out_cyc;
        to      = (trdel >= C_TIMEOUT);
        n_acc   = to ? C_TIMEOUT : trdel + 1;
        a_start = twe ? 3 : 2;
        out_cyc = a_start + n_acc + 1;
        exp_q.push_back(f_vec(1, 0, 0, 1, taddr, 1, 0, 0, 0, 0, 0));
        if (twe)
            exp_q.push_back(f_vec(1, 0, 0, 1, tbm ? {8'h00, twd[7:0]} : twd,
                                  0, 1, 0, 0, 0, 0));
        for (int k = 0; k < n_acc; k++)
            exp_q.push_back(f_vec(1, 0, 0, 0, 16'h0000, 0, 0, 1, twe, tbm, 0));
        if (!twe && !to) begin
            exp_q.push_back(f_vec(1, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0));
            exp_q.push_back(f_vec(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 1));
        end
        exp_q.push_back(f_vec(1, 1, to, 0, 16'h0000, 0, 0, 0, 0, 0, 0));

        req = 1'b1; we = twe; byte_mode = tbm; addr = taddr; wdata = twd;
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 1; i <= exp_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (w_act !== exp_q[i-1]) begin
                errors++;
                $display("FAIL %s cycle %0d strobes got %h want %h",
                         name, i, w_act, exp_q[i-1]);
            end
            if (i >= a_start && i < a_start + n_acc) r = (i - a_start >= trdel);
            else r = 1'($urandom);
            mdr_in = (i == out_cyc) ? tmdr : 16'($urandom);
            req    = 1'($urandom);
        end
        @(negedge clk);
        req = 1'b0;
        if (!twe && !to) model_rdata = tbm ? {8'h00, tmdr[15:8]} : tmdr;
        checks++;
        if (w_act !== 26'h0) begin
            errors++;
            $display("FAIL %s idle strobes got %h want 0", name, w_act);
        end
        checks++;
        if (rdata !== model_rdata) begin
            errors++;
            $display("FAIL %s rdata got %h want %h", name, rdata, model_rdata);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b1; we = 1'b0; byte_mode = 1'b0;
        addr = 16'h1111; wdata = 16'h0000; mdr_in = 16'h0000; r = 1'b1;
        model_rdata = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (w_act !== 26'h0 || rdata !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold got %h/%h want 0/0", w_act, rdata);
            end
        end
        reset = 1'b1;
        run_txn(1'b0, 1'b0, 16'h1111, 16'h0000, 0, 16'h5A5A, "reset_release");
    endtask

    task automatic test_word_read();
        run_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 0, 16'h1234, "word_read");
    endtask

    task automatic test_byte_write();
        run_txn(1'b1, 1'b1, 16'h3001, 16'hABCD, 3, 16'h0000, "byte_write");
    endtask

    task automatic test_byte_read();
        run_txn(1'b0, 1'b1, 16'h3002, 16'h0000, 1, 16'hBEEF, "byte_read");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 1'b0, 16'h3003, 16'h0000, 50, 16'hDEAD, "timeout_read");
        run_txn(1'b1, 1'b0, 16'h3004, 16'h7777, C_TIMEOUT, 16'h0000, "timeout_write");
        run_txn(1'b0, 1'b0, 16'h3005, 16'h0000, C_TIMEOUT - 1, 16'h0F0F, "last_chance_read");
    endtask

    task automatic test_reset_midop();
        logic [25:0] acc_v;
        acc_v = f_vec(1, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 0);
        req = 1'b1; we = 1'b0; byte_mode = 1'b0; addr = 16'h4000; r = 1'b0;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        checks++;
        if (w_act !== f_vec(1, 0, 0, 1, 16'h4000, 1, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL midop_mar got %h", w_act);
        end
        @(negedge clk);
        checks++;
        if (w_act !== acc_v) begin
            errors++;
            $display("FAIL midop_access got %h want %h", w_act, acc_v);
        end
        req = 1'b1; addr = 16'h5555;
        @(negedge clk);
        checks++;
        if (w_act !== acc_v) begin
            errors++;
            $display("FAIL midop_req_ignored got %h want %h", w_act, acc_v);
        end
        req = 1'b0; reset = 1'b0;
        @(negedge clk);
        model_rdata = 16'h0000;
        checks++;
        if (w_act !== 26'h0 || rdata !== 16'h0000) begin
            errors++;
            $display("FAIL midop_reset got %h/%h want 0/0", w_act, rdata);
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (w_act !== 26'h0) begin
                errors++;
                $display("FAIL midop_no_ack got %h want 0", w_act);
            end
        end
        run_txn(1'b0, 1'b0, 16'h4001, 16'h0000, 2, 16'hC0DE, "after_reset_read");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++)
            run_txn(1'b0, 1'(k), 16'(16'h6000 + k), 16'h0000, 0,
                    16'($urandom), "back_to_back");
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++)
            run_txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 5)), 16'($urandom), "random");
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write();
        test_byte_read();
        test_timeout();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
